// File: rtl/gpio_seq_pkg.sv
// rtl/gpio_seq_pkg.sv - register map, response codes and FSM states for the GPIO IRQ sequencer
package gpio_seq_pkg;

    localparam logic [31:0] REG_LED     = 32'h0000_0000;
    localparam logic [31:0] REG_IRQ_STS = 32'h0000_0008;
    localparam logic [31:0] REG_IRQ_ENS = 32'h0000_000C;
    localparam logic [31:0] REG_IRQ_ENC = 32'h0000_0010;
    localparam logic [31:0] REG_DEB     = 32'h0000_0020;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int          STS_W       = 13;

    typedef enum logic [2:0] {
        INIT_DEB,
        INIT_EN,
        IDLE,
        RD_STS,
        WR_CLR,
        WR_LED
    } seq_state_t;

endpackage

// File: rtl/gpio_irq_seq_if.sv
// rtl/gpio_irq_seq_if.sv - AXI4-Lite bundle between the sequencer and the GPIO slave
interface gpio_irq_seq_if;

    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_AWADDR;
    logic [2:0]  M_AWPROT;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [1:0]  M_BRESP;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_ARADDR;
    logic [2:0]  M_ARPROT;
    logic        M_RVALID;
    logic        M_RREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;

    modport master (
        output M_AWVALID, M_AWADDR, M_AWPROT, M_WVALID, M_WDATA, M_WSTRB,
        output M_BREADY, M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_ARREADY,
        input  M_RVALID, M_RDATA, M_RRESP
    );

    modport slave (
        input  M_AWVALID, M_AWADDR, M_AWPROT, M_WVALID, M_WDATA, M_WSTRB,
        input  M_BREADY, M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
        output M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_ARREADY,
        output M_RVALID, M_RDATA, M_RRESP
    );

endinterface

// File: rtl/axi_lite_mst_1tx.sv
// rtl/axi_lite_mst_1tx.sv - single-outstanding AXI4-Lite master; done pulses on the B or R handshake
module axi_lite_mst_1tx
    import gpio_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic           we,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic           done,
    output logic [31:0]    rdata,
    output logic [1:0]     resp,
    gpio_irq_seq_if.master m
);

    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        aw_ok_q, aw_ok_d;
    logic        w_ok_q, w_ok_d;
    logic        b_ready_q, b_ready_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = aw_valid_q & m.M_AWREADY;
    assign w_hs  = w_valid_q & m.M_WREADY;
    assign b_hs  = b_ready_q & m.M_BVALID;
    assign ar_hs = ar_valid_q & m.M_ARREADY;
    assign r_hs  = r_ready_q & m.M_RVALID;
    assign busy  = aw_valid_q | w_valid_q | b_ready_q | ar_valid_q | r_ready_q;

    assign done  = b_hs | r_hs;
    assign rdata = m.M_RDATA;
    assign resp  = r_ready_q ? m.M_RRESP : m.M_BRESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (req && !busy) begin
            addr_d = addr;
            if (we) begin
                aw_valid_d = 1'b1;
                w_valid_d  = 1'b1;
                wdata_d    = wdata;
            end else begin
                ar_valid_d = 1'b1;
            end
        end
        if (aw_hs) begin
            aw_valid_d = 1'b0;
            aw_ok_d    = 1'b1;
        end
        if (w_hs) begin
            w_valid_d = 1'b0;
            w_ok_d    = 1'b1;
        end
        // AW and W may complete in either order; BREADY follows whichever lands last
        if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs) && (aw_hs || w_hs)) begin
            b_ready_d = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
        end
        if (b_hs) b_ready_d = 1'b0;
        if (ar_hs) begin
            ar_valid_d = 1'b0;
            r_ready_d  = 1'b1;
        end
        if (r_hs) r_ready_d = 1'b0;
    end

    assign m.M_AWVALID = aw_valid_q;
    assign m.M_AWADDR  = addr_q;
    assign m.M_AWPROT  = 3'b000;
    assign m.M_WVALID  = w_valid_q;
    assign m.M_WDATA   = wdata_q;
    assign m.M_WSTRB   = 4'b1111;
    assign m.M_BREADY  = b_ready_q;
    assign m.M_ARVALID = ar_valid_q;
    assign m.M_ARADDR  = addr_q;
    assign m.M_ARPROT  = 3'b000;
    assign m.M_RREADY  = r_ready_q;

endmodule

// File: rtl/gpio_irq_seq.sv
// rtl/gpio_irq_seq.sv - initialises a GPIO block, then services its interrupt: read, W1C, LED mirror
module gpio_irq_seq
    import gpio_seq_pkg::*;
#(
    parameter logic [31:0] DEB_CFG    = 32'h0000_0001,
    parameter logic [31:0] IRQ_MASK   = 32'h0000_1FFF,
    parameter int          LED_MIRROR = 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    gpio_irq_seq_if.master   m_axi,
    input  logic             irq,
    output logic             init_done,
    output logic             evt_valid,
    output logic [STS_W-1:0] evt_status,
    output logic [7:0]       err_cnt
);

    seq_state_t       state_q, state_d;
    logic             armed_q, armed_d;
    logic             init_done_q, init_done_d;
    logic             evt_valid_q, evt_valid_d;
    logic [STS_W-1:0] evt_status_q, evt_status_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             req, we, done;
    logic [31:0]      addr, wdata, rdata;
    logic [1:0]       resp;
    logic             sts_hit;
    logic             unused_rdata_hi;

    assign sts_hit         = |rdata[STS_W-1:0];
    assign unused_rdata_hi = ^rdata[31:STS_W];

    axi_lite_mst_1tx u_mst (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .done  (done),
        .rdata (rdata),
        .resp  (resp),
        .m     (m_axi)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= INIT_DEB;
            armed_q      <= 1'b0;
            init_done_q  <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_status_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            init_done_q  <= init_done_d;
            evt_valid_q  <= evt_valid_d;
            evt_status_q <= evt_status_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_DEB: if (done) state_d = INIT_EN;
            INIT_EN:  if (done) state_d = IDLE;
            IDLE:     if (irq) state_d = RD_STS;
            RD_STS:   if (done) state_d = sts_hit ? WR_CLR : IDLE;
            WR_CLR:   if (done) state_d = (LED_MIRROR != 0) ? WR_LED : IDLE;
            WR_LED:   if (done) state_d = IDLE;
            default:  state_d = INIT_DEB;
        endcase
    end

    // armed_q holds off the first request so no VALID rises in the cycle after reset release
    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        case (state_q)
            INIT_DEB: begin
                req   = armed_q;
                we    = 1'b1;
                addr  = REG_DEB;
                wdata = DEB_CFG;
            end
            INIT_EN: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_IRQ_ENS;
                wdata = IRQ_MASK;
            end
            RD_STS: begin
                req  = 1'b1;
                addr = REG_IRQ_STS;
            end
            WR_CLR: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_IRQ_STS;
                wdata = {19'b0, evt_status_q};
            end
            WR_LED: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = REG_LED;
                wdata = {24'b0, evt_status_q[7:0]};
            end
            default: ;
        endcase

        armed_d      = 1'b1;
        init_done_d  = init_done_q | ((state_q == INIT_EN) & done);
        evt_valid_d  = (state_q == RD_STS) & done & sts_hit;
        evt_status_d = evt_valid_d ? rdata[STS_W-1:0] : evt_status_q;
        err_cnt_d    = err_cnt_q;
        if (done && resp != RESP_OKAY && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    assign init_done  = init_done_q;
    assign evt_valid  = evt_valid_q;
    assign evt_status = evt_status_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gpio_irq_seq.sv
// tb/tb_gpio_irq_seq.sv - scoreboard bench: GPIO slave model, expected-transaction queue, monitor
module tb_gpio_irq_seq;
    import gpio_seq_pkg::*;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw_hi;
        int          w_hi;
    } txn_t;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic        irq     = 1'b0;
    logic        init_done, evt_valid;
    logic [12:0] evt_status;
    logic [7:0]  err_cnt;

    gpio_irq_seq_if bus ();

    gpio_irq_seq dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m_axi      (bus),
        .irq        (irq),
        .init_done  (init_done),
        .evt_valid  (evt_valid),
        .evt_status (evt_status),
        .err_cnt    (err_cnt)
    );

    initial forever #5 ACLK = ~ACLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [12:0] exp_evt[$];

    int          aw_delay  = 0;
    bit          ar_hold   = 1'b0;
    bit          irq_force = 1'b0;
    bit          err_all   = 1'b0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    logic [12:0] sts_reg   = '0;
    logic [12:0] inject    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{1'b1, a, d, aw_delay + 1, 1});
    endtask

    task automatic exp_rd(input logic [31:0] a);
        exp_q.push_back('{1'b0, a, 32'h0, 0, 0});
    endtask

    task automatic exp_service(input logic [12:0] s);
        exp_rd(REG_IRQ_STS);
        exp_evt.push_back(s);
        exp_wr(REG_IRQ_STS, {19'b0, s});
        exp_wr(REG_LED, {24'b0, s[7:0]});
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_evt.size() != 0) && n < budget) begin
            @(negedge ACLK); #3;
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || exp_evt.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d txns / %0d events outstanding after %0d cycles, required 0",
                     name, exp_q.size(), exp_evt.size(), n);
            exp_q.delete();
            exp_evt.delete();
        end
        repeat (8) @(negedge ACLK);
        #3;
    endtask

    // GPIO slave: drives its outputs at negedge, then books handshakes due at the next posedge
    initial begin : slave
        int          aw_wait, aw_hi, w_hi;
        bit          aw_seen, w_seen, ar_seen;
        logic [31:0] wr_addr, wr_data, rd_addr;
        logic [3:0]  wr_strb;
        aw_wait = 0; aw_hi = 0; w_hi = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; wr_strb = '0;
        bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0; bus.M_BRESP = 0;
        bus.M_ARREADY = 0; bus.M_RVALID = 0; bus.M_RDATA = 0; bus.M_RRESP = 0;
        forever begin
            @(negedge ACLK);
            irq = (|sts_reg) || irq_force;
            if (!ARESETn) begin
                bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0;
                bus.M_ARREADY = 0; bus.M_RVALID = 0;
                aw_wait = 0; aw_hi = 0; w_hi = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
            end else begin
                bus.M_AWREADY = bus.M_AWVALID && !aw_seen && aw_wait >= aw_delay;
                bus.M_WREADY  = bus.M_WVALID && !w_seen;
                bus.M_BVALID  = aw_seen && w_seen;
                bus.M_BRESP   = (err_all || wr_addr == err_addr) ? 2'b10 : 2'b00;
                bus.M_ARREADY = bus.M_ARVALID && !ar_hold && !ar_seen;
                bus.M_RVALID  = ar_seen;
                bus.M_RDATA   = {19'h2A5A5, sts_reg};
                bus.M_RRESP   = err_all ? 2'b10 : 2'b00;

                if (bus.M_AWVALID) aw_hi++;
                if (bus.M_WVALID) w_hi++;
                if (bus.M_AWVALID && bus.M_AWREADY) begin
                    aw_seen = 1; wr_addr = bus.M_AWADDR; aw_wait = 0;
                end else if (bus.M_AWVALID) begin
                    aw_wait++;
                end
                if (bus.M_WVALID && bus.M_WREADY) begin
                    w_seen = 1; wr_data = bus.M_WDATA; wr_strb = bus.M_WSTRB;
                end
                if (bus.M_BVALID && bus.M_BREADY) begin
                    obs_q.push_back('{1'b1, wr_addr, wr_data, aw_hi, w_hi});
                    check("wstrb", 32'(wr_strb), 32'hF);
                    if (wr_addr == REG_IRQ_STS) begin
                        sts_reg = (sts_reg & ~wr_data[12:0]) | inject;
                        inject  = '0;
                    end
                    aw_seen = 0; w_seen = 0; aw_hi = 0; w_hi = 0;
                end
                if (bus.M_ARVALID && bus.M_ARREADY) begin
                    ar_seen = 1; rd_addr = bus.M_ARADDR;
                end
                if (bus.M_RVALID && bus.M_RREADY) begin
                    obs_q.push_back('{1'b0, rd_addr, 32'h0, 0, 0});
                    ar_seen   = 0;
                    irq_force = 0;
                end
            end
        end
    end

    initial begin : monitor
        txn_t o, e;
        forever begin
            @(negedge ACLK); #1;
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_txn: got %s to 0x%0h, required none",
                             o.is_wr ? "write" : "read", o.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_is_write", 32'(o.is_wr), 32'(e.is_wr));
                    check("txn_addr", o.addr, e.addr);
                    if (e.is_wr) begin
                        check("txn_wdata", o.data, e.data);
                        check("awvalid_cycles", 32'(o.aw_hi), 32'(e.aw_hi));
                        check("wvalid_cycles", 32'(o.w_hi), 32'(e.w_hi));
                    end
                end
            end
            if (evt_valid) begin
                if (exp_evt.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_evt: got evt_status 0x%0h, required no event", evt_status);
                end else begin
                    check("evt_status", 32'(evt_status), 32'(exp_evt.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_valids", 32'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.M_BREADY, bus.M_RREADY}), 32'h0);
        check("rst_addr", bus.M_AWADDR | bus.M_ARADDR | bus.M_WDATA, 32'h0);
        check("rst_status", 32'({init_done, evt_valid, evt_status, err_cnt}), 32'h0);

        exp_wr(REG_DEB, 32'h1);
        exp_wr(REG_IRQ_ENS, 32'h1FFF);
        @(negedge ACLK); #2;
        ARESETn = 1'b1;
        @(negedge ACLK); #1;
        check("first_cycle_valid", 32'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}), 32'h0);
        drain("init", 40);
        check("init_done", 32'(init_done), 32'h1);
        check("init_err_cnt", 32'(err_cnt), 32'h0);

        exp_service(13'h001);
        sts_reg = 13'h001;
        drain("svc_single", 60);

        exp_service(13'h010);
        exp_service(13'h1000);
        inject  = 13'h1000;
        sts_reg = 13'h010;
        drain("svc_back_to_back", 120);

        exp_rd(REG_IRQ_STS);
        irq_force = 1'b1;
        drain("svc_empty", 60);

        aw_delay = 3;
        exp_service(13'h0FF);
        sts_reg = 13'h0FF;
        drain("aw_delayed", 80);
        aw_delay = 0;

        err_addr = REG_IRQ_ENS;
        @(negedge ACLK); #2;
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        exp_wr(REG_DEB, 32'h1);
        exp_wr(REG_IRQ_ENS, 32'h1FFF);
        #2;
        ARESETn = 1'b1;
        drain("init_err", 40);
        check("err_cnt_one", 32'(err_cnt), 32'h1);
        check("init_done_after_err", 32'(init_done), 32'h1);
        err_addr = 32'hFFFF_FFFF;

        err_all = 1'b1;
        exp_service(13'h002);
        sts_reg = 13'h002;
        drain("err_first", 60);
        check("err_cnt_four", 32'(err_cnt), 32'h4);
        for (int i = 0; i < 99; i++) begin
            exp_service(13'h1 << (i % 13));
            sts_reg = 13'h1 << (i % 13);
            drain("err_loop", 60);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'hFF);
        check("init_done_after_errs", 32'(init_done), 32'h1);
        err_all = 1'b0;

        ar_hold   = 1'b1;
        irq_force = 1'b1;
        n = 0;
        while (!bus.M_ARVALID && n < 20) begin
            @(negedge ACLK); #1;
            n++;
        end
        check("arvalid_raised", 32'(bus.M_ARVALID), 32'h1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("rst_arvalid_async", 32'(bus.M_ARVALID), 32'h0);
        check("rst_evt_status", 32'(evt_status), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        irq_force = 1'b0;
        ar_hold   = 1'b0;
        exp_wr(REG_DEB, 32'h1);
        exp_wr(REG_IRQ_ENS, 32'h1FFF);
        repeat (2) @(negedge ACLK);
        #2;
        ARESETn = 1'b1;
        drain("reinit", 40);
        check("reinit_done", 32'(init_done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_irq_seq.md
GPIO_IRQ_SEQ -- requirements
Module: gpio_irq_seq

Interface
REQ-001 Parameter DEB_CFG, default 32'h0000_0001; value written to debouncer register 0x20 at init.
REQ-002 Parameter IRQ_MASK, default 32'h0000_1FFF; value written to interrupt-enable-set register 0x0C at init.
REQ-003 Parameter LED_MIRROR, default 1; when 1, each serviced event is followed by an LED write.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESETn  in  1  asynchronous, active-low reset.
REQ-006 M_AWVALID/M_AWREADY/M_AWADDR[31:0]/M_AWPROT[2:0]  out/in/out/out  AXI4-Lite write address; AWPROT tied 3'b000.
REQ-007 M_WVALID/M_WREADY/M_WDATA[31:0]/M_WSTRB[3:0]  out/in/out/out  write data; WSTRB always 4'b1111 while WVALID.
REQ-008 M_BVALID/M_BREADY/M_BRESP[1:0]  in/out/in  write response.
REQ-009 M_ARVALID/M_ARREADY/M_ARADDR[31:0]/M_ARPROT[2:0]  out/in/out/out  read address; ARPROT tied 3'b000.
REQ-010 M_RVALID/M_RREADY/M_RDATA[31:0]/M_RRESP[1:0]  in/out/in/in  read data.
REQ-011 irq  in  1  level interrupt from GPIO slave.
REQ-012 init_done  out  1  high from end of init sequence until reset.
REQ-013 evt_valid  out  1  one-cycle pulse per serviced non-zero status.
REQ-014 evt_status  out  13  status captured by last service read; held until next event.
REQ-015 err_cnt  out  8  saturating count of non-OKAY BRESP/RRESP.

Function
REQ-016 FSM states SHALL be: INIT_DEB, INIT_EN, IDLE, RD_STS, WR_CLR, WR_LED.
REQ-017 After reset release: INIT_DEB writes DEB_CFG to 0x20, then INIT_EN writes IRQ_MASK to 0x0C, then IDLE with init_done=1.
REQ-018 Write: AWVALID and WVALID asserted in the same cycle; each deasserts the cycle after its own READY is sampled high; address/data stable while VALID.
REQ-019 After both AW and W accepted, BREADY=1 until BVALID sampled high; transaction completes that cycle.
REQ-020 Read: ARVALID held until ARREADY; then RREADY=1 until RVALID; RDATA captured on the RVALID&RREADY cycle.
REQ-021 At most one transaction outstanding; no VALID raised before prior transaction completes.
REQ-022 irq sampled only in IDLE; irq=1 in IDLE -> RD_STS next cycle (read 0x08).
REQ-023 RDATA[12:0]==0 -> back to IDLE, no evt_valid, no write.
REQ-024 RDATA[12:0]!=0 -> evt_status<=RDATA[12:0], evt_valid pulses on capture cycle, then WR_CLR writes {19'b0,RDATA[12:0]} to 0x08 (write-1-to-clear).
REQ-025 After WR_CLR: LED_MIRROR=1 -> WR_LED writes {24'b0,evt_status[7:0]} to 0x00, then IDLE; LED_MIRROR=0 -> IDLE.
REQ-026 irq still high on return to IDLE SHALL start a new service one cycle later; no events lost.
REQ-027 Non-OKAY response increments err_cnt (saturates at 8'hFF); sequence continues unchanged.
REQ-028 Status outputs change only on transaction completion; no combinational path from AXI inputs to AXI VALID outputs.

Reset
REQ-029 ARESETn low asynchronously forces: all VALID/READY outputs 0, addresses/data 0, state INIT_DEB, init_done 0, evt_valid 0, evt_status 0, err_cnt 0.
REQ-030 Reset mid-transaction abandons it; init sequence restarts from INIT_DEB after release.
REQ-031 No AXI VALID asserted in the first cycle after reset release.

Structure
REQ-032 Package gpio_seq_pkg SHALL hold register offsets (0x00, 0x08, 0x0C, 0x10, 0x20), RESP_OKAY=2'b00, and the FSM state enum.
REQ-033 Single-transaction AXI4-Lite master engine SHALL be sub-module axi_lite_mst_1tx (req, we, addr, wdata -> done, rdata, resp); gpio_irq_seq holds only the sequencing FSM.

Verification
REQ-034 Reset release, slave ready always 1 -> writes 0x20<=0x1 then 0x0C<=0x1FFF, init_done=1, err_cnt=0.
REQ-035 irq=1, status reads 0x001 -> evt_valid once, evt_status=0x001, write 0x08<=0x001, write 0x00<=0x01, IDLE.
REQ-036 Slave delays AWREADY 3 cycles, WREADY 0 cycles -> WVALID drops after 1 cycle, AWVALID after 4, single BREADY handshake.
REQ-037 irq=1, status reads 0x000 -> no evt_valid, no writes, return IDLE.
REQ-038 BRESP=2'b10 on 0x0C write -> err_cnt=1, init_done still 1; 300 errors -> err_cnt=0xFF.
REQ-039 ARESETn low while ARVALID=1 -> ARVALID=0 immediately; after release init sequence repeats from 0x20.
